block_nest_checker: RTL and testbench
=====================================

Name: block_nest_checker

Overview:
- Streaming keyword-nesting checker for the byte-serial character bus, one character per valid cycle.
- Successor to the single-pair begin/end checker. It tracks two keyword pairs, begin/end and fork/join, with a real type stack, so crossed pairs such as "begin join" are detected.
- Adds parameterised nesting depth, optional case-insensitivity, a sticky error output and a depth output.
- Sits downstream of the text/UART front end; its outputs feed status LEDs and the lab scoreboard.

Parameters:
MAX_DEPTH, 16, stack entries; legal nesting depth 0..MAX_DEPTH
DEPTH_W, $clog2(MAX_DEPTH+1), width of the depth output (derived, not overridden)
CASE_INSENSITIVE, 1, 1: keyword match ignores ASCII case; 0: lowercase only
ENABLE_FORK, 1, 1: fork/join tracked; 0: fork/join are ordinary words

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
in  input  8  ASCII character
in_valid  input  1  character qualifier; in is ignored when low
balanced  output  1  registered; 1 when the stream so far, treated as ending now, is properly nested
depth  output  DEPTH_W  committed open-block count
error  output  1  sticky fault flag
top_type  output  1  type of innermost open block (0 begin, 1 fork); 0 when depth==0

Behaviour:
- All state updates on posedge clk. reset==0 at an edge takes priority over in_valid.
- Reset values: balanced=1, depth=0, error=0, top_type=0, word buffer empty, stack cleared.
- Tokenising:
  - Delimiter is 8'h20 (space) only.
  - A word is the maximal run of non-space characters. Consecutive spaces form no empty words.
  - A word is a keyword only if it equals the keyword exactly ("ends" and "bbegin" are not keywords).
- Matching:
  - Per-keyword match flags and a saturating 3-bit length counter.
  - With CASE_INSENSITIVE, in is folded to lowercase before comparison (A-Z only).
- Commit: a word commits on the in_valid cycle carrying the space that ends it.
  - begin/fork: push type. If depth==MAX_DEPTH, set error and leave the stack unchanged.
  - end/join: if depth==0, or the top type mismatches (end vs fork, join vs begin), set error. Otherwise pop.
  - Other words: no effect.
- Sticky error: once set, error stays 1 and the stack freezes (no push/pop) until reset.
- Provisional evaluation: balanced is computed as if the word in progress had just committed.
  - Formula: balanced_next = !error_next && (depth after a hypothetical commit of the current partial word)==0, with no hypothetical fault.
  - Example: after "begin en", balanced=0. After the next character 'd', balanced=1. If 'x' follows, balanced returns to 0.
- Latency: balanced, depth, error and top_type reflect the character sampled at edge N immediately after edge N. depth/top_type change only at commit.
- in_valid==0: all state and outputs hold.
- Simultaneous cases:
  - A space committing a faulting word sets error and balanced=0 on the same edge.
  - A reset edge with in_valid=1 discards the character.
- Non-printing or other bytes are ordinary word characters. The length counter saturates at 7, so words longer than 7 characters can never match.

Test Plan:
- Reset low one edge, then "begin end " -> after final 'd' balanced=1; after 'n' of "begin" balanced=0; depth sequence 0→1 (at first space)→0 (at second space); error=0.
- "begin fork join end " with ENABLE_FORK=1 -> depth 1,2,1,0 at each space; top_type 0,1,0,0; final balanced=1.
- "begin join " -> error=1 at the second space and stays 1 through a following "end "; balanced=0; depth holds 1.
- "end " from reset -> error=1, balanced=0; partial "en" beforehand shows balanced=1.
- CASE_INSENSITIVE=1: "BeGiN EnD " -> balanced=1. CASE_INSENSITIVE=0: same stream -> balanced=1 with depth 0 throughout, since no keyword is recognised.
- MAX_DEPTH=2: "begin begin begin " -> error=1 at the third space, depth=2. Then reset low mid-word ("be") -> all outputs at reset values next edge; then "begin end " -> balanced=1.
- in_valid deasserted for 3 cycles mid-word ("beg", gap, "in ") -> identical outputs to the ungapped stream.

Source files
------------

// File: rtl/block_nest_checker.sv
// Streaming begin/end and fork/join nesting checker for a byte-serial character bus.
// Keeps a type stack of open blocks, a sticky error flag, and a provisional "balanced" view.
module block_nest_checker #(
  parameter int   MAX_DEPTH        = 16,
  parameter bit   CASE_INSENSITIVE = 1'b1,
  parameter bit   ENABLE_FORK      = 1'b1,
  localparam int  DEPTH_W          = $clog2(MAX_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         in,
  input  logic               in_valid,
  output logic               balanced,
  output logic [DEPTH_W-1:0] depth,
  output logic               error,
  output logic               top_type
);

  localparam logic [39:0] KW_BEGIN = "begin";
  localparam logic [39:0] KW_END   = {16'h0000, "end"};
  localparam logic [39:0] KW_FORK  = {8'h00, "fork"};
  localparam logic [39:0] KW_JOIN  = {8'h00, "join"};
  localparam logic [7:0]  SPACE    = 8'h20;

  logic [2:0]           len_q, len_d;
  logic                 mBegin_q, mBegin_d, mEnd_q, mEnd_d;
  logic                 mFork_q, mFork_d, mJoin_q, mJoin_d;
  logic [DEPTH_W-1:0]   depth_q, depth_d, hypDepth;
  logic [MAX_DEPTH-1:0] stack_q, stack_d;
  logic                 error_q, error_d;
  logic                 balanced_q, balanced_d;
  logic [7:0]           charLow;
  logic [2:0]           wordNow, wordNext;

  // True when c is the keyword character at position pos (first character in the top byte).
  function automatic logic kwAt(input logic [39:0] kw, input int kwLen,
                                input logic [2:0] pos, input logic [7:0] c);
    logic hit;
    hit = 1'b0;
    if (int'(pos) < kwLen) hit = (c == kw[(kwLen - 1 - int'(pos)) * 8 +: 8]);
    return hit;
  endfunction

  // Returns {opens, closes, isForkType} for a word given its length and prefix flags.
  function automatic logic [2:0] classify(input logic [2:0] len, input logic b,
                                          input logic e, input logic f, input logic j);
    logic isB, isE, isF, isJ;
    isB = b && (len == 3'd5);
    isE = e && (len == 3'd3);
    isF = ENABLE_FORK && f && (len == 3'd4);
    isJ = ENABLE_FORK && j && (len == 3'd4);
    return {isB | isF, isE | isJ, isF | isJ};
  endfunction

  always_comb begin
    len_d      = len_q;
    mBegin_d   = mBegin_q;
    mEnd_d     = mEnd_q;
    mFork_d    = mFork_q;
    mJoin_d    = mJoin_q;
    depth_d    = depth_q;
    stack_d    = stack_q;
    error_d    = error_q;
    balanced_d = balanced_q;
    hypDepth   = depth_q;
    charLow    = (CASE_INSENSITIVE && in >= "A" && in <= "Z") ? (in | 8'h20) : in;
    wordNow    = classify(len_q, mBegin_q, mEnd_q, mFork_q, mJoin_q);
    wordNext   = 3'b000;

    if (in_valid) begin
      if (charLow == SPACE) begin
        if (!error_q) begin
          if (wordNow[2]) begin
            if (depth_q == DEPTH_W'(MAX_DEPTH)) begin
              error_d = 1'b1;
            end else begin
              depth_d = depth_q + DEPTH_W'(1);
              stack_d = (stack_q << 1) | MAX_DEPTH'(wordNow[0]);
            end
          end else if (wordNow[1]) begin
            if (depth_q == '0 || stack_q[0] != wordNow[0]) begin
              error_d = 1'b1;
            end else begin
              depth_d = depth_q - DEPTH_W'(1);
              stack_d = stack_q >> 1;
            end
          end
        end
        len_d    = 3'd0;
        mBegin_d = 1'b1;
        mEnd_d   = 1'b1;
        mFork_d  = 1'b1;
        mJoin_d  = 1'b1;
      end else begin
        len_d    = (len_q == 3'd7) ? 3'd7 : len_q + 3'd1;
        mBegin_d = mBegin_q && kwAt(KW_BEGIN, 5, len_q, charLow);
        mEnd_d   = mEnd_q   && kwAt(KW_END,   3, len_q, charLow);
        mFork_d  = mFork_q  && kwAt(KW_FORK,  4, len_q, charLow);
        mJoin_d  = mJoin_q  && kwAt(KW_JOIN,  4, len_q, charLow);
      end

      // Pretend the partial word commits now; faults it would cause only leave depth unchanged.
      wordNext = classify(len_d, mBegin_d, mEnd_d, mFork_d, mJoin_d);
      hypDepth = depth_d;
      if (wordNext[2] && depth_d != DEPTH_W'(MAX_DEPTH))
        hypDepth = depth_d + DEPTH_W'(1);
      else if (wordNext[1] && depth_d != '0 && stack_d[0] == wordNext[0])
        hypDepth = depth_d - DEPTH_W'(1);
      balanced_d = !error_d && (hypDepth == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      len_q      <= 3'd0;
      mBegin_q   <= 1'b1;
      mEnd_q     <= 1'b1;
      mFork_q    <= 1'b1;
      mJoin_q    <= 1'b1;
      depth_q    <= '0;
      stack_q    <= '0;
      error_q    <= 1'b0;
      balanced_q <= 1'b1;
    end else begin
      len_q      <= len_d;
      mBegin_q   <= mBegin_d;
      mEnd_q     <= mEnd_d;
      mFork_q    <= mFork_d;
      mJoin_q    <= mJoin_d;
      depth_q    <= depth_d;
      stack_q    <= stack_d;
      error_q    <= error_d;
      balanced_q <= balanced_d;
    end
  end

  assign balanced = balanced_q;
  assign depth    = depth_q;
  assign error    = error_q;
  assign top_type = (depth_q != '0) && stack_q[0];

endmodule

// File: tb/tb_block_nest_checker.sv
// Directed bench for block_nest_checker: four parameterisations share one stimulus stream
// and each is checked against hand-computed expectations.
module tb_block_nest_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in;
  logic       in_valid;

  logic       balA, errA, topA;
  logic [4:0] depA;
  logic       balB, errB, topB;
  logic [4:0] depB;
  logic       balC, errC, topC;
  logic [1:0] depC;
  logic       balD, errD, topD;
  logic [4:0] depD;

  int totalCount = 0;
  int badCount   = 0;

  always #5 clk = ~clk;

  // Default configuration: depth 16, case-insensitive, fork/join tracked.
  block_nest_checker #(.MAX_DEPTH(16), .CASE_INSENSITIVE(1'b1), .ENABLE_FORK(1'b1)) dutA (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
    .balanced(balA), .depth(depA), .error(errA), .top_type(topA));

  // Lowercase-only keywords.
  block_nest_checker #(.MAX_DEPTH(16), .CASE_INSENSITIVE(1'b0), .ENABLE_FORK(1'b1)) dutB (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
    .balanced(balB), .depth(depB), .error(errB), .top_type(topB));

  // Shallow stack to reach the overflow fault quickly.
  block_nest_checker #(.MAX_DEPTH(2), .CASE_INSENSITIVE(1'b1), .ENABLE_FORK(1'b1)) dutC (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
    .balanced(balC), .depth(depC), .error(errC), .top_type(topC));

  // fork/join treated as plain words.
  block_nest_checker #(.MAX_DEPTH(16), .CASE_INSENSITIVE(1'b1), .ENABLE_FORK(1'b0)) dutD (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
    .balanced(balD), .depth(depD), .error(errD), .top_type(topD));

  // Counts one comparison and reports it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalCount++;
    if (observed !== expected) begin
      badCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drives one valid character for one edge, then settles 1 time unit past the edge.
  task automatic sendChar(input byte c);
    in       = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input string s);
    for (int i = 0; i < s.len(); i++) sendChar(s[i]);
  endtask

  // One edge of reset low, optionally with a character present that must be discarded.
  task automatic pulseReset(input logic withValid, input byte c);
    reset    = 1'b0;
    in       = c;
    in_valid = withValid;
    @(posedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    in       = 8'h00;
    in_valid = 1'b0;
    #2;
    pulseReset(1'b0, 8'h00);

    // Reset state
    checkOutput("rst_bal", balA, 1);
    checkOutput("rst_dep", depA, 0);
    checkOutput("rst_err", errA, 0);
    checkOutput("rst_top", topA, 0);

    // Basic begin/end
    applyStimulus("begi");
    checkOutput("be_bal_begi", balA, 1);
    applyStimulus("n");
    checkOutput("be_bal_begin", balA, 0);
    checkOutput("be_dep_pre", depA, 0);
    applyStimulus(" ");
    checkOutput("be_dep_sp1", depA, 1);
    checkOutput("be_bal_sp1", balA, 0);
    applyStimulus("en");
    checkOutput("be_bal_en", balA, 0);
    applyStimulus("d");
    checkOutput("be_bal_end", balA, 1);
    checkOutput("be_dep_end", depA, 1);
    applyStimulus(" ");
    checkOutput("be_dep_sp2", depA, 0);
    checkOutput("be_bal_sp2", balA, 1);
    checkOutput("be_err", errA, 0);
    checkOutput("be_balC", balC, 1);

    // Two keyword pairs nested
    pulseReset(1'b0, 8'h00);
    applyStimulus("begin ");
    checkOutput("bf_dep1", depA, 1);
    checkOutput("bf_top1", topA, 0);
    applyStimulus("fork ");
    checkOutput("bf_dep2", depA, 2);
    checkOutput("bf_top2", topA, 1);
    checkOutput("bf_depD2", depD, 1);
    applyStimulus("join ");
    checkOutput("bf_dep3", depA, 1);
    checkOutput("bf_top3", topA, 0);
    applyStimulus("end ");
    checkOutput("bf_dep4", depA, 0);
    checkOutput("bf_top4", topA, 0);
    checkOutput("bf_bal", balA, 1);
    checkOutput("bf_errD", errD, 0);
    checkOutput("bf_balD", balD, 1);

    // Crossed pair is a sticky fault
    pulseReset(1'b0, 8'h00);
    applyStimulus("begin join");
    checkOutput("x_err_pre", errA, 0);
    applyStimulus(" ");
    checkOutput("x_err", errA, 1);
    checkOutput("x_bal", balA, 0);
    checkOutput("x_dep", depA, 1);
    applyStimulus("end ");
    checkOutput("x_err_hold", errA, 1);
    checkOutput("x_dep_hold", depA, 1);
    checkOutput("x_bal_hold", balA, 0);

    // Underflow
    pulseReset(1'b0, 8'h00);
    applyStimulus("en");
    checkOutput("u_bal_en", balA, 1);
    applyStimulus("d ");
    checkOutput("u_err", errA, 1);
    checkOutput("u_bal", balA, 0);
    checkOutput("u_dep", depA, 0);

    // Case folding
    pulseReset(1'b0, 8'h00);
    applyStimulus("BeGiN");
    checkOutput("c_balA_N", balA, 0);
    checkOutput("c_balB_N", balB, 1);
    applyStimulus(" ");
    checkOutput("c_depA_sp", depA, 1);
    checkOutput("c_depB_sp", depB, 0);
    applyStimulus("EnD ");
    checkOutput("c_balA", balA, 1);
    checkOutput("c_depA", depA, 0);
    checkOutput("c_balB", balB, 1);
    checkOutput("c_depB", depB, 0);
    checkOutput("c_errB", errB, 0);

    // Overflow at MAX_DEPTH=2, then reset mid-word with a valid character present
    pulseReset(1'b0, 8'h00);
    applyStimulus("begin begin ");
    checkOutput("o_depC2", depC, 2);
    checkOutput("o_errC2", errC, 0);
    applyStimulus("begin ");
    checkOutput("o_errC", errC, 1);
    checkOutput("o_depC", depC, 2);
    checkOutput("o_balC", balC, 0);
    checkOutput("o_depA", depA, 3);
    checkOutput("o_errA", errA, 0);
    applyStimulus("be");
    pulseReset(1'b1, "g");
    checkOutput("o_rst_bal", balC, 1);
    checkOutput("o_rst_dep", depC, 0);
    checkOutput("o_rst_err", errC, 0);
    checkOutput("o_rst_top", topC, 0);
    applyStimulus("begin end ");
    checkOutput("o_after_bal", balC, 1);
    checkOutput("o_after_dep", depC, 0);

    // Gap in in_valid mid-word, with junk on the data lines
    pulseReset(1'b0, 8'h00);
    applyStimulus("beg");
    in = 8'h20;
    for (int g = 0; g < 3; g++) begin
      @(posedge clk);
      #1;
      checkOutput("g_bal_gap", balA, 1);
      checkOutput("g_dep_gap", depA, 0);
    end
    applyStimulus("in");
    checkOutput("g_bal_in", balA, 0);
    applyStimulus(" ");
    checkOutput("g_dep", depA, 1);
    checkOutput("g_bal", balA, 0);
    checkOutput("g_err", errA, 0);
    applyStimulus("end ");
    checkOutput("g_bal_end", balA, 1);

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
